alu_exec_unit: RTL and testbench
================================

# alu_exec_unit

Parametrised execute-stage ALU for the RV32I core, successor to the combinational ALU-control decoder. It decodes ALUOp/funct3/funct7 internally and adds SRA/SRAI, SLT/SLTU(I) and an optional iterative MUL. Every result is registered behind a valid/ready handshake on both sides. It sits between the decode/register-read stage and writeback, and is parametrised for width and for the multiply option.

## Interface
- XLEN, 32: operand/result width; power of two, ≥8
- MUL_EN, 1: 1 enables the serial MUL path; 0 decodes MUL encodings as ADD
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operation offered
- in_ready  out  1  unit can accept this cycle
- alu_op  in  2  00 load/store, 01 branch, 10 R-type, 11 I-type
- funct3  in  3  instruction funct3
- funct7  in  7  instruction funct7 (for I-type shifts: imm[11:5])
- op_a  in  XLEN  rs1 value
- op_b  in  XLEN  rs2 value or sign-extended immediate
- out_valid  out  1  result held valid
- out_ready  in  1  consumer accepts result
- result  out  XLEN  registered result
- zero  out  1  registered (result == 0)

## Operation
- Internal 4-bit codes: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001, MUL 1010.
- Decode:
  - alu_op 00 → ADD.
  - alu_op 01 → SUB.
  - alu_op 10, funct3 (000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND) with these overrides:
    - funct7 = 0100000 turns 000 into SUB and 101 into SRA.
    - funct7 = 0000001 with MUL_EN = 1 and funct3 = 000 → MUL.
    - funct7 = 0000001 with any other funct3 → ADD.
  - alu_op 11: same funct3 map, never SUB; funct7 = 0100000 with funct3 101 → SRA.
- Shift amount is op_b[$clog2(XLEN)-1:0]; upper op_b bits are ignored.
- SLT is signed, SLTU unsigned; result is 1 or 0, zero-extended.
- ADD/SUB/MUL wrap modulo 2^XLEN; MUL returns the low XLEN bits only.
- FSM states: IDLE, MUL_RUN.
  - IDLE: a handshake (in_valid & in_ready) of a non-MUL op loads result/zero at the same edge and sets out_valid. A MUL handshake latches the operands, clears the accumulator, loads count = XLEN and moves to MUL_RUN.
  - MUL_RUN: each cycle, if multiplier bit0 = 1 then acc += multiplicand; multiplicand <<= 1; multiplier >>= 1; count−1. When count reaches 0, write acc to result, set out_valid and return to IDLE.
- in_ready = (state == IDLE) & (!out_valid | out_ready), so a new op may be accepted in the same cycle the old result drains.
- out_valid clears on (out_valid & out_ready) unless a new result loads at the same edge.
- result and zero are held stable while out_valid & !out_ready.
- Async rst in any state, including mid-MUL:
  - state goes to IDLE; out_valid, result, zero, acc and count go to 0.
  - Any in-flight MUL is discarded; in_ready = 1 one cycle after rst deasserts.

## Timing
- Non-MUL latency: 1 cycle from the accepting edge to out_valid high.
- Back-to-back throughput: 1 op/cycle with out_ready held high.
- MUL latency: XLEN+1 edges from the accepting edge to out_valid (33 at XLEN = 32). in_ready is low throughout MUL_RUN.
- If out_valid & !out_ready when a MUL completes: not possible, because MUL is accepted only when the output is free or draining.
- in_ready is combinational from state, out_valid and out_ready; there is no combinational path from in_valid to out_valid.

## Structure
- Package alu_pkg:
  - localparams for the 4-bit ALU codes;
  - ALUOp encodings ALUOP_MEM, ALUOP_BR, ALUOP_R, ALUOP_I;
  - FUNCT7_ALT = 0100000 and FUNCT7_MULDIV = 0000001;
  - a pure decode function returning the 4-bit code (shared with any future forwarding logic).
- Sub-module alu_mul_serial (XLEN): start/busy/done plus the shift-add datapath. alu_exec_unit owns the handshake, decode, single-cycle datapath and output register.

## Test plan
- Reset mid-MUL: start MUL 7×9, assert rst on cycle 10 → out_valid = 0, result = 0; after release in_ready = 1 and no stale result ever appears.
- Back-to-back: ADD 5+3, SUB 5−8, SRA (0x80000000 >>> 4), SLTU (1 < 0xFFFFFFFF), out_ready = 1 → results 8, 0xFFFFFFFD, 0xF8000000, 1 on four consecutive cycles.
- Decode overrides:
  - alu_op 11, f3 000, funct7 0100000, op_a = 10, op_b = 3 → 13 (no SUB).
  - alu_op 10, same fields → 7.
  - alu_op 01, 4−4 → result 0, zero = 1.
- MUL: op_a = 0xFFFFFFFF, op_b = 3 → result 0xFFFFFFFD exactly 33 cycles after accept; in_ready low for cycles 1–32. With MUL_EN = 0 → 2 after 1 cycle.
- Backpressure: XOR 0xF0F0 ^ 0x0FF0 with out_ready = 0 for 5 cycles → result 0xFF00 held stable, in_ready = 0; raising out_ready together with a new in_valid drains and accepts on the same edge.
- Shift masking at XLEN = 8: SLL 0x01 by op_b = 0x0B → 0x08 (amount 3).

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU operation codes, ALUOp/funct7 encodings and the instruction decode
// used by the execute stage (and any later forwarding logic).
package alu_pkg;

    typedef logic [3:0] alu_code_t;

    localparam alu_code_t ALU_ADD  = 4'b0000;
    localparam alu_code_t ALU_SUB  = 4'b0001;
    localparam alu_code_t ALU_AND  = 4'b0010;
    localparam alu_code_t ALU_OR   = 4'b0011;
    localparam alu_code_t ALU_XOR  = 4'b0100;
    localparam alu_code_t ALU_SLL  = 4'b0101;
    localparam alu_code_t ALU_SRL  = 4'b0110;
    localparam alu_code_t ALU_SRA  = 4'b0111;
    localparam alu_code_t ALU_SLT  = 4'b1000;
    localparam alu_code_t ALU_SLTU = 4'b1001;
    localparam alu_code_t ALU_MUL  = 4'b1010;

    localparam logic [1:0] ALUOP_MEM = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [1:0] ALUOP_I   = 2'b11;

    localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    function automatic alu_code_t funct3_code(input logic [2:0] funct3);
        alu_code_t code;
        case (funct3)
            3'b000:  code = ALU_ADD;
            3'b001:  code = ALU_SLL;
            3'b010:  code = ALU_SLT;
            3'b011:  code = ALU_SLTU;
            3'b100:  code = ALU_XOR;
            3'b101:  code = ALU_SRL;
            3'b110:  code = ALU_OR;
            default: code = ALU_AND;
        endcase
        return code;
    endfunction

    function automatic alu_code_t alu_decode(input logic [1:0] alu_op,
                                             input logic [2:0] funct3,
                                             input logic [6:0] funct7,
                                             input logic       mul_en);
        alu_code_t code;
        code = funct3_code(funct3);
        case (alu_op)
            ALUOP_MEM: code = ALU_ADD;
            ALUOP_BR:  code = ALU_SUB;
            ALUOP_R: begin
                if (funct7 == FUNCT7_ALT) begin
                    if (funct3 == 3'b000)
                        code = ALU_SUB;
                    else if (funct3 == 3'b101)
                        code = ALU_SRA;
                end else if (funct7 == FUNCT7_MULDIV) begin
                    code = (mul_en && funct3 == 3'b000) ? ALU_MUL : ALU_ADD;
                end
            end
            default: begin
                // Immediates never subtract; only the shift-right form uses imm[11:5].
                if (funct7 == FUNCT7_ALT && funct3 == 3'b101)
                    code = ALU_SRA;
            end
        endcase
        return code;
    endfunction

endpackage

// File: rtl/alu_mul_serial.sv
// Serial shift-add multiplier: one multiplier bit per cycle, low XLEN bits kept.
// done is asserted during the final iteration; product is valid in that cycle.
module alu_mul_serial
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] product
);

    localparam int CW = $clog2(XLEN) + 1;

    logic [XLEN-1:0] mcand;
    logic [XLEN-1:0] mplier;
    logic [XLEN-1:0] acc;
    logic [XLEN-1:0] acc_next;
    logic [CW-1:0]   count;

    assign acc_next = mplier[0] ? acc + mcand : acc;
    assign busy     = (count != '0);
    assign done     = (count == CW'(1));
    assign product  = acc_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
        end else if (start) begin
            mcand  <= op_a;
            mplier <= op_b;
            acc    <= '0;
            count  <= CW'(XLEN);
        end else if (busy) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count - CW'(1);
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// RV32I execute-stage ALU: decode, single-cycle datapath, optional serial MUL,
// and a registered result behind valid/ready handshakes.
//   state   | meaning
//   IDLE    | accepting ops; single-cycle results load directly
//   MUL_RUN | serial multiply in progress, input side stalled
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      alu_op,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    localparam int SW = $clog2(XLEN);

    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_MUL_RUN = 1'b1;

    logic [0:0]      state;
    alu_code_t       code;
    logic [XLEN-1:0] alu_res;
    logic [SW-1:0]   shamt;
    logic            accept;
    logic            is_mul;
    logic            mul_start;
    logic            mul_busy;
    logic            mul_done;
    logic [XLEN-1:0] mul_product;

    assign code      = alu_decode(alu_op, funct3, funct7, MUL_EN);
    assign shamt     = op_b[SW-1:0];
    assign is_mul    = (code == ALU_MUL);
    assign in_ready  = (state == S_IDLE) && !mul_busy && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && is_mul;

    always_comb begin
        alu_res = '0;
        case (code)
            ALU_ADD:  alu_res = op_a + op_b;
            ALU_SUB:  alu_res = op_a - op_b;
            ALU_AND:  alu_res = op_a & op_b;
            ALU_OR:   alu_res = op_a | op_b;
            ALU_XOR:  alu_res = op_a ^ op_b;
            ALU_SLL:  alu_res = op_a << shamt;
            ALU_SRL:  alu_res = op_a >> shamt;
            ALU_SRA:  alu_res = $unsigned($signed(op_a) >>> shamt);
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            default:  alu_res = '0;
        endcase
    end

    generate
        if (MUL_EN) begin : g_mul
            alu_mul_serial #(.XLEN(XLEN)) u_mul (
                .clk     (clk),
                .rst     (rst),
                .start   (mul_start),
                .op_a    (op_a),
                .op_b    (op_b),
                .busy    (mul_busy),
                .done    (mul_done),
                .product (mul_product)
            );
        end else begin : g_nomul
            assign mul_busy    = 1'b0;
            assign mul_done    = 1'b0;
            assign mul_product = '0;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
        end else begin
            // Drain first; a result loaded on the same edge overrides the clear.
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept && !is_mul) begin
                        result    <= alu_res;
                        zero      <= (alu_res == '0);
                        out_valid <= 1'b1;
                    end else if (mul_start) begin
                        state <= S_MUL_RUN;
                    end
                end
                default: begin
                    if (mul_done) begin
                        result    <= mul_product;
                        zero      <= (mul_product == '0);
                        out_valid <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: vector table plus multi-cycle MUL,
// backpressure, reset and width/option variants.
module tb_alu_exec_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // XLEN=32, MUL_EN=1
    logic        d_in_valid, d_in_ready, d_out_valid, d_out_ready, d_zero;
    logic [1:0]  d_alu_op;
    logic [2:0]  d_funct3;
    logic [6:0]  d_funct7;
    logic [31:0] d_op_a, d_op_b, d_result;

    // XLEN=32, MUL_EN=0
    logic        n_in_valid, n_in_ready, n_out_valid, n_out_ready, n_zero;
    logic [1:0]  n_alu_op;
    logic [2:0]  n_funct3;
    logic [6:0]  n_funct7;
    logic [31:0] n_op_a, n_op_b, n_result;

    // XLEN=8, MUL_EN=1
    logic        e_in_valid, e_in_ready, e_out_valid, e_out_ready, e_zero;
    logic [1:0]  e_alu_op;
    logic [2:0]  e_funct3;
    logic [6:0]  e_funct7;
    logic [7:0]  e_op_a, e_op_b, e_result;

    alu_exec_unit #(.XLEN(32), .MUL_EN(1'b1)) u_dut (
        .clk(clk), .rst(rst), .in_valid(d_in_valid), .in_ready(d_in_ready),
        .alu_op(d_alu_op), .funct3(d_funct3), .funct7(d_funct7),
        .op_a(d_op_a), .op_b(d_op_b), .out_valid(d_out_valid),
        .out_ready(d_out_ready), .result(d_result), .zero(d_zero));

    alu_exec_unit #(.XLEN(32), .MUL_EN(1'b0)) u_nomul (
        .clk(clk), .rst(rst), .in_valid(n_in_valid), .in_ready(n_in_ready),
        .alu_op(n_alu_op), .funct3(n_funct3), .funct7(n_funct7),
        .op_a(n_op_a), .op_b(n_op_b), .out_valid(n_out_valid),
        .out_ready(n_out_ready), .result(n_result), .zero(n_zero));

    alu_exec_unit #(.XLEN(8), .MUL_EN(1'b1)) u_x8 (
        .clk(clk), .rst(rst), .in_valid(e_in_valid), .in_ready(e_in_ready),
        .alu_op(e_alu_op), .funct3(e_funct3), .funct7(e_funct7),
        .op_a(e_op_a), .op_b(e_op_b), .out_valid(e_out_valid),
        .out_ready(e_out_ready), .result(e_result), .zero(e_zero));

    typedef struct {
        logic [1:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic        expz;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_d(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [31:0] a, input logic [31:0] b);
        d_in_valid = 1'b1;
        d_alu_op   = op;
        d_funct3   = f3;
        d_funct7   = f7;
        d_op_a     = a;
        d_op_b     = b;
    endtask

    initial begin
        vecs[0]  = '{2'b10, 3'b000, 7'h00, 32'd5,        32'd3,        32'd8,        1'b0};
        vecs[1]  = '{2'b10, 3'b000, 7'h20, 32'd5,        32'd8,        32'hFFFFFFFD, 1'b0};
        vecs[2]  = '{2'b10, 3'b101, 7'h20, 32'h80000000, 32'd4,        32'hF8000000, 1'b0};
        vecs[3]  = '{2'b10, 3'b011, 7'h00, 32'd1,        32'hFFFFFFFF, 32'd1,        1'b0};
        vecs[4]  = '{2'b11, 3'b000, 7'h20, 32'd10,       32'd3,        32'd13,       1'b0};
        vecs[5]  = '{2'b10, 3'b000, 7'h20, 32'd10,       32'd3,        32'd7,        1'b0};
        vecs[6]  = '{2'b01, 3'b000, 7'h00, 32'd4,        32'd4,        32'd0,        1'b1};
        vecs[7]  = '{2'b00, 3'b010, 7'h00, 32'd256,      32'hFFFFFFFC, 32'd252,      1'b0};
        vecs[8]  = '{2'b10, 3'b010, 7'h00, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0};
        vecs[9]  = '{2'b10, 3'b010, 7'h00, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b1};
        vecs[10] = '{2'b10, 3'b111, 7'h00, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b0};
        vecs[11] = '{2'b10, 3'b110, 7'h00, 32'h0000F0F0, 32'h00000F0F, 32'h0000FFFF, 1'b0};
        vecs[12] = '{2'b10, 3'b001, 7'h00, 32'd1,        32'h00000024, 32'h00000010, 1'b0};
        vecs[13] = '{2'b10, 3'b101, 7'h00, 32'h80000000, 32'd4,        32'h08000000, 1'b0};
        vecs[14] = '{2'b11, 3'b101, 7'h20, 32'h80000000, 32'h0000001F, 32'hFFFFFFFF, 1'b0};
        vecs[15] = '{2'b10, 3'b010, 7'h01, 32'd7,        32'd9,        32'd16,       1'b0};
        vecs[16] = '{2'b10, 3'b011, 7'h00, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1};

        d_in_valid = 0; d_out_ready = 1; drive_d(2'b00, 3'b000, 7'h00, 32'd0, 32'd0); d_in_valid = 0;
        n_in_valid = 0; n_out_ready = 1; n_alu_op = 0; n_funct3 = 0; n_funct7 = 0; n_op_a = 0; n_op_b = 0;
        e_in_valid = 0; e_out_ready = 1; e_alu_op = 0; e_funct3 = 0; e_funct7 = 0; e_op_a = 0; e_op_b = 0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {31'b0, d_out_valid}, 32'd0);
        check("rst_result", d_result, 32'd0);
        check("rst_zero", {31'b0, d_zero}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", {31'b0, d_in_ready}, 32'd1);

        // Back-to-back table, one op per cycle
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive_d(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].a, vecs[i].b);
            #1;
            check($sformatf("vec%0d_in_ready", i), {31'b0, d_in_ready}, 32'd1);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_out_valid", i), {31'b0, d_out_valid}, 32'd1);
            check($sformatf("vec%0d_result", i), d_result, vecs[i].exp);
            check($sformatf("vec%0d_zero", i), {31'b0, d_zero}, {31'b0, vecs[i].expz});
        end
        @(negedge clk);
        d_in_valid = 0;
        @(posedge clk);
        #1;
        check("drain_out_valid", {31'b0, d_out_valid}, 32'd0);

        // Backpressure: XOR held while consumer stalls, then drain + accept on one edge
        @(negedge clk);
        d_out_ready = 0;
        drive_d(2'b10, 3'b100, 7'h00, 32'h0000F0F0, 32'h00000FF0);
        @(posedge clk);
        #1;
        check("bp_first_result", d_result, 32'h0000FF00);
        @(negedge clk);
        drive_d(2'b10, 3'b000, 7'h00, 32'd1, 32'd2);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp_hold_result%0d", k), d_result, 32'h0000FF00);
            check($sformatf("bp_hold_valid%0d", k), {31'b0, d_out_valid}, 32'd1);
            check($sformatf("bp_in_ready%0d", k), {31'b0, d_in_ready}, 32'd0);
        end
        @(negedge clk);
        d_out_ready = 1;
        #1;
        check("bp_release_in_ready", {31'b0, d_in_ready}, 32'd1);
        @(posedge clk);
        #1;
        check("bp_new_result", d_result, 32'd3);
        check("bp_new_valid", {31'b0, d_out_valid}, 32'd1);
        @(negedge clk);
        d_in_valid = 0;

        // MUL 0xFFFFFFFF * 3: in_ready low cycles 1..32, result on cycle 33
        @(negedge clk);
        drive_d(2'b10, 3'b000, 7'h01, 32'hFFFFFFFF, 32'd3);
        #1;
        check("mul_accept_ready", {31'b0, d_in_ready}, 32'd1);
        @(posedge clk);
        #1;
        d_in_valid = 0;
        for (int k = 1; k <= 32; k++) begin
            check($sformatf("mul_busy_ready_c%0d", k), {31'b0, d_in_ready}, 32'd0);
            check($sformatf("mul_busy_valid_c%0d", k), {31'b0, d_out_valid}, 32'd0);
            @(posedge clk);
            #1;
        end
        check("mul_done_valid", {31'b0, d_out_valid}, 32'd1);
        check("mul_done_result", d_result, 32'hFFFFFFFD);
        check("mul_done_zero", {31'b0, d_zero}, 32'd0);
        check("mul_done_in_ready", {31'b0, d_in_ready}, 32'd1);

        // Reset mid-MUL 7*9 on cycle 10
        @(negedge clk);
        drive_d(2'b10, 3'b000, 7'h01, 32'd7, 32'd9);
        @(posedge clk);
        #1;
        d_in_valid = 0;
        repeat (9) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rstmul_out_valid", {31'b0, d_out_valid}, 32'd0);
        check("rstmul_result", d_result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rstmul_in_ready", {31'b0, d_in_ready}, 32'd1);
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("rstmul_no_stale%0d", k), {31'b0, d_out_valid}, 32'd0);
        end

        // MUL_EN=0: the MUL encoding is an ADD with 1-cycle latency
        @(negedge clk);
        n_in_valid = 1; n_alu_op = 2'b10; n_funct3 = 3'b000; n_funct7 = 7'h01;
        n_op_a = 32'hFFFFFFFF; n_op_b = 32'd3;
        @(posedge clk);
        #1;
        check("nomul_valid", {31'b0, n_out_valid}, 32'd1);
        check("nomul_result", n_result, 32'd2);
        @(negedge clk);
        n_in_valid = 0;

        // XLEN=8: shift amount masked to 3 bits
        @(negedge clk);
        e_in_valid = 1; e_alu_op = 2'b10; e_funct3 = 3'b001; e_funct7 = 7'h00;
        e_op_a = 8'h01; e_op_b = 8'h0B;
        @(posedge clk);
        #1;
        check("x8_sll_result", {24'b0, e_result}, 32'h08);
        check("x8_sll_valid", {31'b0, e_out_valid}, 32'd1);

        // XLEN=8 MUL 0x0F*0x11: result appears exactly on cycle 9
        @(negedge clk);
        e_funct3 = 3'b000; e_funct7 = 7'h01; e_op_a = 8'h0F; e_op_b = 8'h11;
        @(posedge clk);
        #1;
        e_in_valid = 0;
        check("x8_mul_c1_valid", {31'b0, e_out_valid}, 32'd0);
        repeat (7) @(posedge clk);
        #1;
        check("x8_mul_c8_valid", {31'b0, e_out_valid}, 32'd0);
        @(posedge clk);
        #1;
        check("x8_mul_c9_valid", {31'b0, e_out_valid}, 32'd1);
        check("x8_mul_result", {24'b0, e_result}, 32'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
